// File: rtl/rt_lim_array_shift_ctrl.sv
// Clocked racetrack LiM array: shared shift-alignment controller, valid/ready
// request/response handshake and a per-array LiM program register.
module rt_lim_array_shift_ctrl #(
    parameter int unsigned NR    = 4,
    parameter int unsigned NB    = 32,
    parameter int unsigned NP    = 8,
    parameter int unsigned AW    = $clog2(NB),
    parameter int unsigned CNT_W = 32,
    localparam int unsigned NSP  = NB / NP,
    localparam int unsigned PW   = (NSP > 1) ? $clog2(NSP) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [NR-1:0]    req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [NR-1:0]    rsp_data_o,
    output logic             rsp_err_o,
    output logic             shift_pulse_o,
    output logic             shift_dir_o,
    output logic [PW-1:0]    pos_o,
    output logic [CNT_W-1:0] shift_cnt_o
);

    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, ACCESS, RESP} state_e;
    typedef enum logic [2:0] {
        OP_RD_DATA = 3'd0,
        OP_RD_LIM  = 3'd1,
        OP_WR_DATA = 3'd2,
        OP_WR_MASK = 3'd3,
        OP_WR_PROG = 3'd4
    } op_e;

    if (NB % NP != 0) begin : g_geom_check
        $error("NB must be a multiple of NP");
    end

    state_e           state_q, state_d;
    op_e              op_q;
    logic [IW-1:0]    addr_q;
    logic [NR-1:0]    wdata_q;
    logic [PW-1:0]    tgt_q;
    logic             err_q;
    logic [NR-1:0]    rsp_data_q;
    logic [PW-1:0]    pos_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       prog_q;
    logic [NR-1:0]    data_mem [NB];
    logic [NR-1:0]    mask_mem [NB];

    logic             req_bad;
    logic [PW-1:0]    req_off;
    logic             shift_up;
    logic [PW-1:0]    pos_step;
    logic [NR-1:0]    lim_res;

    always_comb begin
        req_bad  = (req_op_i > 3'd4) ||
                   ((req_op_i != OP_WR_PROG) && ({1'b0, req_addr_i} >= (AW+1)'(NB)));
        req_off  = PW'({1'b0, req_addr_i} % (AW+1)'(NSP));
        shift_up = tgt_q > pos_q;
        pos_step = shift_up ? pos_q + PW'(1) : pos_q - PW'(1);
    end

    always_comb begin
        unique case (prog_q)
            2'd0:    lim_res = data_mem[addr_q] & mask_mem[addr_q];
            2'd1:    lim_res = data_mem[addr_q] | mask_mem[addr_q];
            2'd2:    lim_res = data_mem[addr_q] ^ mask_mem[addr_q];
            default: lim_res = ~(data_mem[addr_q] & mask_mem[addr_q]);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        rsp_data_o    = '0;
        rsp_err_o     = 1'b0;
        shift_pulse_o = 1'b0;
        shift_dir_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_bad)
                        state_d = RESP;
                    else if (req_op_i == OP_WR_PROG || req_off == pos_q)
                        state_d = ACCESS;
                    else
                        state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_pulse_o = 1'b1;
                shift_dir_o   = shift_up;
                if (pos_step == tgt_q) state_d = ACCESS;
            end
            ACCESS: state_d = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = rsp_data_q;
                rsp_err_o   = err_q;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= OP_RD_DATA;
            addr_q     <= '0;
            wdata_q    <= '0;
            tgt_q      <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            pos_q      <= '0;
            cnt_q      <= '0;
            prog_q     <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                data_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: if (req_valid_i) begin
                    op_q       <= op_e'(req_op_i);
                    addr_q     <= req_addr_i[IW-1:0];
                    wdata_q    <= req_wdata_i;
                    err_q      <= req_bad;
                    rsp_data_q <= '0;
                    // WR_PROG targets the current alignment so it never shifts
                    tgt_q      <= (req_op_i == OP_WR_PROG) ? pos_q : req_off;
                end
                SHIFT: begin
                    pos_q <= pos_step;
                    if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                end
                ACCESS: begin
                    unique case (op_q)
                        OP_RD_DATA: rsp_data_q <= data_mem[addr_q];
                        OP_RD_LIM:  rsp_data_q <= lim_res;
                        OP_WR_DATA: data_mem[addr_q] <= wdata_q;
                        OP_WR_MASK: mask_mem[addr_q] <= wdata_q;
                        OP_WR_PROG: prog_q <= wdata_q[1:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign pos_o       = pos_q;
    assign shift_cnt_o = cnt_q;

endmodule

// File: tb/tb_rt_lim_array_shift_ctrl.sv
// Directed bench for rt_lim_array_shift_ctrl (NSP = 4, AW widened to 6 for
// out-of-range addresses); immediate assertions at every comparison point.
module tb_rt_lim_array_shift_ctrl;

    localparam int unsigned NR = 4, NB = 32, NP = 8, AW = 6, CNT_W = 32, PW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [2:0]       req_op;
    logic [AW-1:0]    req_addr;
    logic [NR-1:0]    req_wdata;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [NR-1:0]    rsp_data;
    logic             shift_pulse, shift_dir;
    logic [PW-1:0]    pos;
    logic [CNT_W-1:0] shift_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rt_lim_array_shift_ctrl #(
        .NR(NR), .NB(NB), .NP(NP), .AW(AW), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .shift_pulse_o(shift_pulse), .shift_dir_o(shift_dir),
        .pos_o(pos), .shift_cnt_o(shift_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One full transaction; lat counts edges from acceptance to rsp_valid.
    task automatic txn(input logic [2:0] op, input logic [AW-1:0] addr,
                       input logic [NR-1:0] wd, output int lat, output int npulse,
                       output int nup, output logic [NR-1:0] d, output logic e);
        chk("accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; npulse = 0; nup = 0;
        while (!rsp_valid && lat < 50) begin
            if (shift_pulse) begin
                npulse++;
                if (shift_dir) nup++;
            end
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_data; e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, np, nup;
        logic [NR-1:0] d;
        logic e;
        logic [NR-1:0] lim_exp [4];
        logic stray_rsp;
        lim_exp = '{4'h8, 4'hE, 4'h6, 4'h7};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_cnt", shift_cnt, 32'd0);
        chk("rst_pulse", 32'(shift_pulse), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(3'd2, 6'd13, 4'hA, lat, np, nup, d, e);
        chk("wr13_lat", 32'(lat), 32'd3);
        chk("wr13_pulses", 32'(np), 32'd1);
        chk("wr13_dir_up", 32'(nup), 32'd1);
        chk("wr13_data", 32'(d), 32'd0);
        chk("wr13_pos", 32'(pos), 32'd1);

        txn(3'd0, 6'd13, 4'h0, lat, np, nup, d, e);
        chk("rd13_lat", 32'(lat), 32'd2);
        chk("rd13_pulses", 32'(np), 32'd0);
        chk("rd13_data", 32'(d), 32'hA);

        txn(3'd0, 6'd3, 4'h0, lat, np, nup, d, e);
        chk("rd3_lat", 32'(lat), 32'd4);
        chk("rd3_pulses", 32'(np), 32'd2);
        chk("rd3_dir_up", 32'(nup), 32'd2);
        chk("rd3_pos", 32'(pos), 32'd3);

        txn(3'd0, 6'd8, 4'h0, lat, np, nup, d, e);
        chk("rd8_lat", 32'(lat), 32'd5);
        chk("rd8_pulses", 32'(np), 32'd3);
        chk("rd8_dir_up", 32'(nup), 32'd0);
        chk("rd8_pos", 32'(pos), 32'd0);
        chk("cnt_after_rd8", shift_cnt, 32'd6);

        txn(3'd2, 6'd5, 4'hC, lat, np, nup, d, e);
        txn(3'd3, 6'd5, 4'hA, lat, np, nup, d, e);
        chk("wrmask_err", 32'(e), 32'd0);
        for (int k = 0; k < 4; k++) begin
            txn(3'd4, 6'd0, 4'(k), lat, np, nup, d, e);
            chk("wrprog_lat", 32'(lat), 32'd2);
            chk("wrprog_pulses", 32'(np), 32'd0);
            txn(3'd1, 6'd5, 4'h0, lat, np, nup, d, e);
            chk($sformatf("lim_prog%0d", k), 32'(d), 32'(lim_exp[k]));
        end
        chk("cnt_after_lim", shift_cnt, 32'd7);

        txn(3'd0, 6'd40, 4'h0, lat, np, nup, d, e);
        chk("oob_err", 32'(e), 32'd1);
        chk("oob_data", 32'(d), 32'd0);
        chk("oob_pulses", 32'(np), 32'd0);
        chk("oob_lat", 32'(lat), 32'd1);
        chk("oob_pos", 32'(pos), 32'd1);
        chk("oob_cnt", shift_cnt, 32'd7);

        txn(3'd6, 6'd5, 4'h0, lat, np, nup, d, e);
        chk("op6_err", 32'(e), 32'd1);
        chk("op6_data", 32'(d), 32'd0);
        chk("op6_pulses", 32'(np), 32'd0);

        // Backpressure with a second request waiting behind the response
        req_valid = 1'b1; req_op = 3'd0; req_addr = 6'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_rsp_rise", 32'(rsp_valid), 32'd1);
        req_valid = 1'b1; req_op = 3'd0; req_addr = 6'd13;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_data_c%0d", c), 32'(rsp_data), 32'hC);
            chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_rsp_fall", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_second_valid", 32'(rsp_valid), 32'd1);
        chk("bp_second_data", 32'(rsp_data), 32'hA);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during the second of three shift cycles of a write
        txn(3'd0, 6'd0, 4'h0, lat, np, nup, d, e);
        chk("realign_pos", 32'(pos), 32'd0);
        req_valid = 1'b1; req_op = 3'd2; req_addr = 6'd7; req_wdata = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rs_shift1", 32'(shift_pulse), 32'd1);
        @(posedge clk); #1;
        chk("rs_shift2", 32'(shift_pulse), 32'd1);
        chk("rs_pos_mid", 32'(pos), 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_pos", 32'(pos), 32'd0);
        chk("rs_cnt", shift_cnt, 32'd0);
        chk("rs_pulse", 32'(shift_pulse), 32'd0);
        chk("rs_req_ready", 32'(req_ready), 32'd1);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stray_rsp = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) stray_rsp = 1'b1;
        end
        chk("rs_no_response", 32'(stray_rsp), 32'd0);

        txn(3'd0, 6'd7, 4'h0, lat, np, nup, d, e);
        chk("rs_rd7_data", 32'(d), 32'd0);
        chk("rs_rd7_pulses", 32'(np), 32'd3);
        chk("rs_rd7_dir_up", 32'(nup), 32'd3);
        chk("rs_cnt_after", shift_cnt, 32'd3);
        txn(3'd0, 6'd13, 4'h0, lat, np, nup, d, e);
        chk("rs_rd13_cleared", 32'(d), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rt_lim_array_shift_ctrl.md
Name: rt_lim_array_shift_ctrl

Overview:
- Parametrised, clocked successor to the combinational racetrack LiM array.
- Models NR racetracks of NB domains each, read and written through NP access ports.
- Adds what the combinational array lacks: a shift-alignment controller that moves all tracks to the domain offset a request needs, a valid/ready request/response handshake, and a per-array LiM program register.
- Sits between the core's LiM memory interface and the racetrack storage model in the core testbench.

Parameters:
- NR, 4, racetracks per array; equals the word width in bits.
- NB, 32, domains per racetrack; must be a multiple of NP (elaboration $error otherwise).
- NP, 8, access ports per racetrack.
- AW, $clog2(NB), address width.
- CNT_W, 32, width of the shift statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  3  0 RD_DATA, 1 RD_LIM, 2 WR_DATA, 3 WR_MASK, 4 WR_PROG; 5-7 are reserved.
- req_addr_i  in  AW  domain address.
- req_wdata_i  in  NR  write data; for WR_PROG only bits [1:0] are used.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  NR  read result; 0 for writes and errors.
- rsp_err_o  out  1  response carries an error.
- shift_pulse_o  out  1  one domain shift is occurring this cycle.
- shift_dir_o  out  1  shift direction: 1 = toward higher offset, 0 = lower.
- pos_o  out  $clog2(NB/NP) (minimum 1)  current track alignment offset.
- shift_cnt_o  out  CNT_W  total shifts performed; saturates at all-ones.

Behaviour:
- Geometry: NSP = NB/NP positions per port segment. Address a maps to port a/NSP and offset a%NSP. All tracks shift together, so a single alignment register pos is shared.
- Storage: data[NB][NR] and mask[NB][NR] arrays plus a 2-bit prog register (0 AND, 1 OR, 2 XOR, 3 NAND).
- LiM result = data[a] prog mask[a], applied bitwise.
- Reset: asynchronous, effective immediately.
  - State goes to IDLE; pos = 0; shift_cnt_o = 0; prog = 0.
  - All data and mask bits go to 0.
  - All outputs go to 0 except req_ready_o = 1 once in IDLE.
  - Reset mid-shift or mid-response abandons the transaction; no response is issued and no partial write occurs.
- FSM states: IDLE, SHIFT, ACCESS, RESP.
- IDLE:
  - req_ready_o = 1; it is 0 in every other state.
  - On req_valid_i & req_ready_o, latch op, addr and wdata.
  - If addr >= NB or op >= 5, go to RESP with rsp_err_o = 1. No shift and no write occur.
  - Otherwise compute d = offset - pos. If d == 0, go to ACCESS; else go to SHIFT.
  - WR_PROG ignores the address and always goes to ACCESS with no shift.
- SHIFT:
  - Each cycle: shift_pulse_o = 1 and shift_dir_o = (offset > pos).
  - pos moves by ±1 at the clock edge; shift_cnt_o increments (saturating).
  - Go to ACCESS at the edge where pos reaches offset.
  - Exactly |d| cycles are spent in SHIFT. Tracks are linear, so pos never wraps.
- ACCESS: one cycle, then RESP.
  - RD_DATA captures data[a].
  - RD_LIM captures the LiM result.
  - WR_DATA writes data[a].
  - WR_MASK writes mask[a].
  - WR_PROG writes prog.
- RESP:
  - rsp_valid_o = 1; rsp_data_o and rsp_err_o are held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i, return to IDLE. rsp_valid_o falls on the next edge.
  - Writes also produce a response: data 0, err 0.
- Latency: from the acceptance edge, rsp_valid_o rises after |d| + 2 edges (2 edges when no shift is needed).
- Throughput: one outstanding transaction; no new request is accepted until the response completes.
- Read-after-write to the same address returns the new value; ordering is guaranteed by the single-outstanding rule.
- shift_pulse_o is 0 in every state other than SHIFT.

Test Plan (defaults, NSP = 4):
- Reset, then WR_DATA addr 13 (offset 1), wdata 0xA -> 1 shift, shift_dir_o = 1, rsp_valid_o 3 edges after accept, pos_o = 1. RD_DATA addr 13 -> 0 shifts, rsp_data_o = 0xA in 2 edges.
- From pos 1, RD_DATA addr 3 (offset 3) -> 2 pulses with dir 1, then RD_DATA addr 8 (offset 0) -> 3 pulses with dir 0; shift_cnt_o = 6 total including the first scenario.
- WR_DATA addr 5 = 0xC, WR_MASK addr 5 = 0xA; WR_PROG 0/1/2/3 each followed by RD_LIM addr 5 -> 0x8, 0xE, 0x6, 0x7.
- RD_DATA addr 40 with NB = 32, AW widened so 40 is representable -> rsp_err_o = 1, rsp_data_o = 0, no shift pulse, pos unchanged. Op 6 -> error likewise.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and rsp_data_o stable, req_ready_o = 0 throughout, and a second req_valid_i is not accepted until one cycle after the response handshake.
- Assert rst_i during the 2nd of 3 SHIFT cycles of a WR_DATA -> immediately IDLE, pos_o = 0, shift_cnt_o = 0, no response; a subsequent read of that address returns 0.
